pixel_scan_feeder: RTL and testbench

Frame source for the edge-detection pipeline, sitting at the input end of one single-direction edge-detection unit. Holds one 8-bit greyscale frame in on-chip memory, loaded over a write port. On `start`, it streams the frame one pixel per cycle in a selected scan order (across, down, up, reverse-across). Alongside the pixels it produces the scan index consumed by the edge buffer and a per-line reset pulse that restarts the smoothing and derivative stages at every line boundary.

---
 rtl/pixel_scan_feeder.sv | 170 +++++++++++++++++
 tb/tb_pixel_scan_feeder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scan_feeder.sv
// Frame memory plus scan-order address generator feeding one edge-detection unit.
// Optional `FEEDER_LINE_RESET_EN: pulse line_reset before every line instead of once per frame.
module pixel_scan_feeder #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              start,
  input  logic [2:0]        mode,
  output logic [7:0]        pix_out,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] cnt,
  output logic              line_reset,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] W_SZ     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] DEPTH_M1 = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE_RST,
    S_STREAM,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SCAN_ACROSS,
    SCAN_DOWN,
    SCAN_UP,
    SCAN_REV
  } scan_t;

  state_t            state_q, state_d;
  scan_t             scan_q, scan_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        pix_q;
  logic              valid_q;
  logic [ADDR_W-1:0] cnt_q;

  logic              rd_en;
  logic [MEM_AW-1:0] rd_addr;
  logic              mem_we;
  logic [MEM_AW-1:0] wr_addr;
  logic [ADDR_W-1:0] pos_last;
  logic [ADDR_W-1:0] line_last;
  logic              col_major;

  logic [7:0] mem [DEPTH];

  always_comb begin
    col_major = (scan_q == SCAN_DOWN) || (scan_q == SCAN_UP);
    pos_last  = col_major ? H_LAST : W_LAST;
    line_last = col_major ? W_LAST : H_LAST;

    // Within a line pos_q walks the fast axis; line_q walks the slow axis.
    unique case (scan_q)
      SCAN_DOWN: rd_addr = MEM_AW'(pos_q * W_SZ + line_q);
      SCAN_UP:   rd_addr = MEM_AW'((H_LAST - pos_q) * W_SZ + line_q);
      SCAN_REV:  rd_addr = MEM_AW'(line_q * W_SZ + (W_LAST - pos_q));
      default:   rd_addr = MEM_AW'(line_q * W_SZ + pos_q);
    endcase
  end

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    line_d  = line_q;
    pos_d   = pos_q;
    idx_d   = idx_q;
    rd_en   = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        mem_we = load_we && (load_addr <= DEPTH_M1);
        if (start) begin
          unique case (mode)
            3'd1:    scan_d = SCAN_DOWN;
            3'd2:    scan_d = SCAN_UP;
            3'd3:    scan_d = SCAN_REV;
            default: scan_d = SCAN_ACROSS;
          endcase
          line_d  = '0;
          pos_d   = '0;
          idx_d   = '0;
          state_d = S_LINE_RST;
        end
      end
      S_LINE_RST: state_d = S_STREAM;
      S_STREAM: begin
        rd_en = 1'b1;
        idx_d = idx_q + 1'b1;
        if (pos_q == pos_last) begin
          pos_d = '0;
          if (line_q == line_last) begin
            state_d = S_DONE;
          end else begin
            line_d = line_q + 1'b1;
`ifdef FEEDER_LINE_RESET_EN
            state_d = S_LINE_RST;
`else
            state_d = S_STREAM;
`endif
          end
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      S_DONE: begin
        // Hold here until the final read has been presented on pix_out.
        if (!valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      scan_q  <= SCAN_ACROSS;
      line_q  <= '0;
      pos_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (enb) begin
      state_q <= state_d;
      scan_q  <= scan_d;
      line_q  <= line_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      valid_q <= rd_en;
      if (rd_en) begin
        pix_q <= mem[rd_addr];
        cnt_q <= idx_q;
      end
    end
  end

  assign wr_addr = MEM_AW'(load_addr);

  // Frame memory is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && enb && mem_we) mem[wr_addr] <= load_data;
  end

  assign pix_out    = pix_q;
  assign pix_valid  = valid_q;
  assign cnt        = cnt_q;
  assign line_reset = (state_q == S_LINE_RST);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) && !valid_q;

endmodule

// File: tb/tb_pixel_scan_feeder.sv
// Randomized self-checking bench for pixel_scan_feeder on a 4x3 frame.
module tb_pixel_scan_feeder;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int D  = W * H;
`ifdef FEEDER_LINE_RESET_EN
  localparam bit PER_LINE = 1'b1;
`else
  localparam bit PER_LINE = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          enb;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          start;
  logic [2:0]    mode;
  logic [7:0]    pix_out;
  logic          pix_valid;
  logic [AW-1:0] cnt;
  logic          line_reset;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] model_mem [D];

  pixel_scan_feeder #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .enb(enb),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .mode(mode),
    .pix_out(pix_out), .pix_valid(pix_valid), .cnt(cnt),
    .line_reset(line_reset), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scan ordinal of the pixel visible at un-stalled cycle v, or -1 if none.
  function automatic int exp_index(input int v, input int L, input int N);
    int o;
    if (v < 3) return -1;
    o = v - 3;
    if (PER_LINE) begin
      if ((o / (L + 1)) < N && (o % (L + 1)) < L) return (o / (L + 1)) * L + (o % (L + 1));
      return -1;
    end
    if (o < N * L) return o;
    return -1;
  endfunction

  function automatic bit exp_lrst(input int v, input int L, input int N);
    if (PER_LINE) return (v >= 1) && ((v - 1) % (L + 1) == 0) && ((v - 1) / (L + 1) < N);
    return v == 1;
  endfunction

  function automatic int done_cycle(input int L, input int N);
    return PER_LINE ? N * (L + 1) + 2 : N * L + 3;
  endfunction

  // Frame address of the k-th pixel in the given effective scan order.
  function automatic int frame_addr(input int m, input int k);
    case (m)
      1: return (k % H) * W + k / H;
      2: return (H - 1 - k % H) * W + k / H;
      3: return (k / W) * W + (W - 1 - k % W);
      default: return k;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    n_cmp++;
    if ({pix_out, pix_valid, cnt, line_reset, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL %s: pix=%0d valid=%0b cnt=%0d lrst=%0b busy=%0b done=%0b, all required 0",
               tag, pix_out, pix_valid, cnt, line_reset, busy, done);
    end
  endtask

  task automatic load_mem(input bit ramp);
    for (int a = 0; a < D; a++) begin
      load_we   = 1'b1;
      load_addr = AW'(a);
      load_data = ramp ? 8'(a) : 8'($urandom);
      model_mem[a] = load_data;
      tick();
    end
    load_we = 1'b0;
  endtask

  // stall: 0 none, 1 enb low at cycles 8..10, 2 random.
  task automatic run_scan(input int m, input int stall, input bit inject,
                          input bit same_write, input int reset_at);
    int eff, L, N, dv, v, k, a;
    bit fin, ev, el, eb, ed;
    eff = (m >= 1 && m <= 3) ? m : 0;
    L   = (eff == 1 || eff == 2) ? H : W;
    N   = (eff == 1 || eff == 2) ? W : H;
    dv  = done_cycle(L, N);
    v   = 0;
    fin = 1'b0;
    for (int t = 0; t < 400 && !fin; t++) begin
      start   = (t == 0);
      mode    = (t == 0) ? 3'(m) : 3'($urandom);
      load_we = 1'b0;
      enb     = 1'b1;
      if (t > 0 && stall == 1) enb = !(t >= 8 && t <= 10);
      if (t > 0 && stall == 2) enb = ($urandom_range(0, 3) != 0);
      if (t == 0 && same_write) begin
        a = $urandom_range(0, D - 1);
        load_we = 1'b1; load_addr = AW'(a); load_data = 8'($urandom);
        model_mem[a] = load_data;
      end
      if (inject && t > 0 && v >= 1 && v <= dv) begin
        start     = 1'($urandom_range(0, 1));
        load_we   = 1'($urandom_range(0, 1));
        load_addr = ($urandom_range(0, 1) == 1) ? AW'(5) : AW'($urandom_range(0, D - 1));
        load_data = 8'hAA;
      end
      if (t == reset_at) reset = 1'b0;
      @(negedge clk);
      k  = exp_index(v, L, N);
      ev = (k >= 0);
      el = exp_lrst(v, L, N);
      eb = (v >= 1) && (v <= dv);
      ed = (v == dv);
      n_cmp++;
      if (pix_valid !== ev) begin
        n_bad++;
        $display("FAIL valid m=%0d t=%0d: got %0b want %0b", m, t, pix_valid, ev);
      end
      if (ev && pix_valid === 1'b1) begin
        n_cmp++;
        if (pix_out !== model_mem[frame_addr(eff, k)]) begin
          n_bad++;
          $display("FAIL pixel m=%0d t=%0d k=%0d: got %0d want %0d", m, t, k, pix_out,
                   model_mem[frame_addr(eff, k)]);
        end
        n_cmp++;
        if (cnt !== AW'(k)) begin
          n_bad++;
          $display("FAIL cnt m=%0d t=%0d: got %0d want %0d", m, t, cnt, k);
        end
      end
      n_cmp++;
      if (line_reset !== el) begin
        n_bad++;
        $display("FAIL line_reset m=%0d t=%0d: got %0b want %0b", m, t, line_reset, el);
      end
      n_cmp++;
      if (busy !== eb) begin
        n_bad++;
        $display("FAIL busy m=%0d t=%0d: got %0b want %0b", m, t, busy, eb);
      end
      n_cmp++;
      if (done !== ed) begin
        n_bad++;
        $display("FAIL done m=%0d t=%0d: got %0b want %0b", m, t, done, ed);
      end
      if (v == dv + 1) fin = 1'b1;
      tick();
      if (enb) v++;
      if (t == reset_at) begin
        reset = 1'b1; start = 1'b0; load_we = 1'b0; enb = 1'b1;
        @(negedge clk);
        check_idle_zero("mid_scan_reset");
        tick();
        return;
      end
    end
    start = 1'b0; load_we = 1'b0; enb = 1'b1;
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout m=%0d: frame did not complete, want done at cycle %0d", m, dv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enb = 1'b1; start = 1'b1; mode = 3'd0;
    tick(); tick();
    start = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_values");
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_idle_zero("idle_after_reset");
    tick();
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) run_scan(m, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_enb_stall();
    run_scan(0, 1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_mid_reset();
    run_scan(0, 0, 1'b0, 1'b0, 9);
    run_scan(0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_busy_ignore();
    run_scan(0, 0, 1'b1, 1'b0, -1);
    run_scan(0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reserved_mode();
    run_scan(6, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      load_mem(1'b0);
      for (int s = 0; s < 8; s++)
        run_scan($urandom_range(0, 7), 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    reset = 1'b0; enb = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; mode = '0;
    test_reset();
    load_mem(1'b1);
    test_modes();
    test_enb_stall();
    test_mid_reset();
    test_busy_ignore();
    test_reserved_mode();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
